// File: rtl/battle_turn_sequencer_if.sv
// Bundle between the battle turn sequencer and its environment (map logic, key input, damage engine).
// master drives the battle inputs and observes strobes; slave is the sequencer itself.
interface battle_turn_sequencer_if;
  logic       collision_detected;
  logic       key_valid;
  logic [1:0] key_code;
  logic       player_win;
  logic       enemy_win;
  logic [4:0] player_remained_sword;
  logic [4:0] player_remained_baseballbat;
  logic [4:0] enemy_remained_sword;
  logic [4:0] enemy_remained_baseballbat;
  logic [1:0] player_choice;
  logic [1:0] enemy_choice;
  logic       player_turn;
  logic       attacker_turn;
  logic       battle_active;
  logic       waiting_key;
  logic       key_reject;
  logic [7:0] turn_count;

  modport master (
    output collision_detected, key_valid, key_code, player_win, enemy_win,
           player_remained_sword, player_remained_baseballbat,
           enemy_remained_sword, enemy_remained_baseballbat,
    input  player_choice, enemy_choice, player_turn, attacker_turn,
           battle_active, waiting_key, key_reject, turn_count
  );

  modport slave (
    input  collision_detected, key_valid, key_code, player_win, enemy_win,
           player_remained_sword, player_remained_baseballbat,
           enemy_remained_sword, enemy_remained_baseballbat,
    output player_choice, enemy_choice, player_turn, attacker_turn,
           battle_active, waiting_key, key_reject, turn_count
  );
endinterface

// File: rtl/battle_turn_sequencer.sv
// Alternates player/enemy strikes for the damage engine; all outputs registered, strobes one cycle wide.
// No backpressure: keys arriving outside P_WAIT are dropped silently, illegal keys in P_WAIT pulse key_reject.
module battle_turn_sequencer #(
  parameter int          SETTLE_CYCLES = 3,
  parameter int          THINK_CYCLES  = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic                    clk,
  input logic                    rst,
  battle_turn_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, P_WAIT, P_STRIKE, P_SETTLE, E_THINK, E_STRIKE, E_SETTLE, DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [7:0] THINK_LAST  = 8'(THINK_CYCLES);

  state_t      state_q;
  logic        coll_q;
  logic        low_seen_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [7:0]  cnt_q;
  logic [1:0]  player_choice_q;
  logic [1:0]  enemy_choice_q;
  logic        player_turn_q;
  logic        attacker_turn_q;
  logic        battle_active_q;
  logic        waiting_key_q;
  logic        key_reject_q;
  logic [7:0]  turn_count_q;

  logic [1:0]  enemy_pick_d;
  logic        key_legal_d;
  logic        start_d;
  logic        win_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // S degrades to B without swords, and B (original or degraded) to K without bats.
  always_comb begin
    enemy_pick_d = lfsr_q[1:0];
    if (enemy_pick_d == 2'b11 && bus.enemy_remained_sword == 5'd0) begin
      enemy_pick_d = 2'b10;
    end
    if (enemy_pick_d == 2'b10 && bus.enemy_remained_baseballbat == 5'd0) begin
      enemy_pick_d = 2'b01;
    end
  end

  always_comb begin
    key_legal_d = !((bus.key_code == 2'b10 && bus.player_remained_baseballbat == 5'd0) ||
                    (bus.key_code == 2'b11 && bus.player_remained_sword == 5'd0));
    win_d       = bus.player_win | bus.enemy_win;
    // The edge register clears on reset, so also demand a low level first; otherwise
    // a reset with collision held high would look like a fresh battle start.
    start_d     = bus.collision_detected & ~coll_q & low_seen_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      coll_q          <= 1'b0;
      low_seen_q      <= 1'b0;
      lfsr_q          <= LFSR_SEED;
      cnt_q           <= 8'd0;
      player_choice_q <= 2'b00;
      enemy_choice_q  <= 2'b00;
      player_turn_q   <= 1'b0;
      attacker_turn_q <= 1'b0;
      battle_active_q <= 1'b0;
      waiting_key_q   <= 1'b0;
      key_reject_q    <= 1'b0;
      turn_count_q    <= 8'd0;
    end else begin
      lfsr_q          <= lfsr_d;
      coll_q          <= bus.collision_detected;
      if (!bus.collision_detected) low_seen_q <= 1'b1;
      player_turn_q   <= 1'b0;
      attacker_turn_q <= 1'b0;
      key_reject_q    <= 1'b0;

      if (!bus.collision_detected && state_q != IDLE) begin
        state_q         <= IDLE;
        battle_active_q <= 1'b0;
        waiting_key_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_d) begin
              state_q         <= P_WAIT;
              battle_active_q <= 1'b1;
              waiting_key_q   <= 1'b1;
              turn_count_q    <= 8'd0;
            end
          end
          P_WAIT: begin
            if (bus.key_valid) begin
              if (key_legal_d) begin
                state_q         <= P_STRIKE;
                player_choice_q <= bus.key_code;
                player_turn_q   <= 1'b1;
                waiting_key_q   <= 1'b0;
              end else begin
                key_reject_q    <= 1'b1;
              end
            end
          end
          P_STRIKE: begin
            state_q <= P_SETTLE;
            cnt_q   <= 8'd0;
          end
          P_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q <= 8'd0;
              if (win_d) begin
                state_q         <= DONE;
                battle_active_q <= 1'b0;
              end else begin
                state_q <= E_THINK;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          E_THINK: begin
            if (cnt_q == THINK_LAST) begin
              state_q         <= E_STRIKE;
              enemy_choice_q  <= enemy_pick_d;
              attacker_turn_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          E_STRIKE: begin
            state_q <= E_SETTLE;
            cnt_q   <= 8'd0;
          end
          E_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q <= 8'd0;
              if (turn_count_q != 8'hFF) turn_count_q <= turn_count_q + 8'd1;
              if (win_d) begin
                state_q         <= DONE;
                battle_active_q <= 1'b0;
              end else begin
                state_q       <= P_WAIT;
                waiting_key_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q         <= IDLE;
            battle_active_q <= 1'b0;
            waiting_key_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.player_choice = player_choice_q;
  assign bus.enemy_choice  = enemy_choice_q;
  assign bus.player_turn   = player_turn_q;
  assign bus.attacker_turn = attacker_turn_q;
  assign bus.battle_active = battle_active_q;
  assign bus.waiting_key   = waiting_key_q;
  assign bus.key_reject    = key_reject_q;
  assign bus.turn_count    = turn_count_q;

endmodule

// File: doc/battle_turn_sequencer.md
# battle_turn_sequencer

Turn controller that sits directly upstream of the battle damage engine. It detects battle start from `collision_detected` and alternates player and enemy turns. It accepts legal player key choices, generates enemy attack choices from an LFSR with ammo-aware fallback, and issues single-cycle `player_turn`/`attacker_turn` strobes with stable choice codes. It stops the battle when the engine reports a winner.

## Interface
- `SETTLE_CYCLES`, default 3: cycles waited after a strike strobe before sampling win flags; legal range 2–15.
- `THINK_CYCLES`, default 8: enemy "thinking" delay before its strike; legal range 1–255.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `collision_detected` in 1: battle-active level from the map logic.
- `key_valid` in 1: one-cycle pulse; a player attack key was pressed.
- `key_code` in 2: attack code, P=00, K=01, B=10, S=11.
- `player_win` in 1: win flag from the engine.
- `enemy_win` in 1: win flag from the engine.
- `player_remained_sword` in 5: player sword ammo from the engine.
- `player_remained_baseballbat` in 5: player bat ammo from the engine.
- `enemy_remained_sword` in 5: enemy sword ammo from the engine.
- `enemy_remained_baseballbat` in 5: enemy bat ammo from the engine.
- `player_choice` out 2: registered player attack code, held until the next accepted key.
- `enemy_choice` out 2: registered enemy attack code, held until the next enemy strike.
- `player_turn` out 1: one-cycle strike strobe for the player.
- `attacker_turn` out 1: one-cycle strike strobe for the enemy.
- `battle_active` out 1: high in every state except IDLE and DONE.
- `waiting_key` out 1: high in P_WAIT.
- `key_reject` out 1: one-cycle pulse when a key is refused for lack of ammo.
- `turn_count` out 8: completed rounds; saturates at 255.

## Operation
- States: IDLE, P_WAIT, P_STRIKE, P_SETTLE, E_THINK, E_STRIKE, E_SETTLE, DONE.
- IDLE → P_WAIT on a rising edge of `collision_detected`. The edge is detected against a registered copy of the input, and `turn_count` clears to 0 on that transition.
- P_WAIT:
  - On `key_valid`, the key is illegal if it is B with `player_remained_baseballbat`==0, or S with `player_remained_sword`==0. An illegal key pulses `key_reject` and the FSM stays in P_WAIT.
  - A legal key is latched into `player_choice` and the FSM moves to P_STRIKE.
- P_STRIKE lasts one cycle: `player_turn`=1, then the FSM moves to P_SETTLE.
- P_SETTLE counts `SETTLE_CYCLES` cycles, then samples the win flags. Either flag set → DONE; otherwise → E_THINK.
- E_THINK counts `THINK_CYCLES` cycles. On exit, `enemy_choice` is loaded from `lfsr[1:0]` with this fallback:
  - S with sword ammo 0 → B.
  - B with bat ammo 0 → K. This also applies to an S that fell back to B.
- E_STRIKE lasts one cycle: `attacker_turn`=1, then the FSM moves to E_SETTLE.
- E_SETTLE waits as P_SETTLE does. On exit, `turn_count` increments (saturating at 255). Either win flag set → DONE; otherwise → P_WAIT.
- DONE holds until `collision_detected`=0, then goes to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including during reset release, and never reaches 0.
- `key_valid` is ignored outside P_WAIT, with no reject pulse.

## Timing
- Reset (synchronous, clock edge with `rst`=1) sets:
  - state IDLE;
  - all outputs 0, including `player_choice`, `enemy_choice` and `turn_count`;
  - LFSR = `LFSR_SEED`;
  - edge register = 0.
- Reset mid-battle returns to IDLE even if `collision_detected` stays high. A new rising edge is then required to start a battle.
- Key accepted at edge N → `player_choice` and `player_turn` are valid together from edge N+1, and `player_turn` lasts exactly one cycle.
- The first win-flag sample happens `SETTLE_CYCLES`+1 cycles after the strobe deasserts.
- The enemy strobe follows P_SETTLE exit by `THINK_CYCLES`+1 cycles. `enemy_choice` updates on the same edge that raises `attacker_turn`.
- `collision_detected` falling in any state → IDLE on the next edge. No strobe is issued on that edge or later.
- `player_turn` and `attacker_turn` are never high in the same cycle, and are never high outside P_STRIKE/E_STRIKE.

## Test plan
- Reset, then raise `collision_detected` at cycle 5 → `battle_active`=1 and `waiting_key`=1 at cycle 7; all other outputs 0.
- In P_WAIT, pulse `key_valid` with `key_code`=01 → next cycle `player_choice`=01 and `player_turn`=1 for exactly one cycle. After `SETTLE_CYCLES`=3 and `THINK_CYCLES`=8, `attacker_turn` pulses once and `turn_count`=1 after E_SETTLE.
- `player_remained_sword`=0 with key S → `key_reject` pulses, no `player_turn`, FSM stays in P_WAIT. Then key B with bats=3 → accepted.
- Enemy ammo sword=0 and bat=0 with the LFSR forced to an S/B code over many rounds → `enemy_choice` is always 00 or 01.
- `enemy_win` asserted during P_SETTLE → DONE, no `attacker_turn`. `collision_detected` low → IDLE; a new rising edge → P_WAIT with `turn_count`=0.
- Drop `collision_detected` during E_THINK, then assert `rst` mid-battle with collision held high → no strobes and IDLE in both cases; the battle restarts only after collision goes low then high.
